// File: rtl/alu_operand_if.sv
// Bundles the ID/EX beat, the forwarding sources and the ALU-side handshake of alu_operand_stage.
interface alu_operand_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned CNT_W   = 16
);
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [2:0]         src_sel;
  logic [4:0]         rs_addr;
  logic [4:0]         rt_addr;
  logic [DATA_W-1:0]  rs_data;
  logic [DATA_W-1:0]  rt_data;
  logic [SHAMT_W-1:0] shamt;
  logic [IMM_W-1:0]   imm;
  logic               exm_wen;
  logic [4:0]         exm_waddr;
  logic [DATA_W-1:0]  exm_wdata;
  logic               mwb_wen;
  logic [4:0]         mwb_waddr;
  logic [DATA_W-1:0]  mwb_wdata;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  op1;
  logic [DATA_W-1:0]  op2;
  logic               sel_err;
  logic [CNT_W-1:0]   fwd_hits;

  modport master (
    output in_valid, flush, src_sel, rs_addr, rt_addr, rs_data, rt_data, shamt, imm,
           exm_wen, exm_waddr, exm_wdata, mwb_wen, mwb_waddr, mwb_wdata, out_ready,
    input  in_ready, out_valid, op1, op2, sel_err, fwd_hits
  );

  modport slave (
    input  in_valid, flush, src_sel, rs_addr, rt_addr, rs_data, rt_data, shamt, imm,
           exm_wen, exm_waddr, exm_wdata, mwb_wen, mwb_waddr, mwb_wdata, out_ready,
    output in_ready, out_valid, op1, op2, sel_err, fwd_hits
  );
endinterface

// File: rtl/alu_operand_stage.sv
// EX-stage operand selector: forwards from EX/MEM and MEM/WB, builds op1/op2 per mode,
// and holds the result in a one-entry valid/ready register with flush and a forward-hit counter.
module alu_operand_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_operand_if.slave bus
);

  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] b_val;
  logic              a_fwd;
  logic              b_fwd;
  logic [DATA_W-1:0] op1_n;
  logic [DATA_W-1:0] op2_n;
  logic              err_n;
  logic              uses_a;
  logic              uses_b;
  logic              hit;
  logic              in_ready;
  logic              accept;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic              sel_err_q, sel_err_d;
  logic [CNT_W-1:0]  fwd_hits_q, fwd_hits_d;

  // Bypass network; EX/MEM has priority, register 0 is never forwarded.
  always_comb begin
    a_val = bus.rs_data;
    a_fwd = 1'b0;
    if (bus.rs_addr != 5'd0 && bus.exm_wen && bus.exm_waddr == bus.rs_addr) begin
      a_val = bus.exm_wdata;
      a_fwd = 1'b1;
    end else if (bus.rs_addr != 5'd0 && bus.mwb_wen && bus.mwb_waddr == bus.rs_addr) begin
      a_val = bus.mwb_wdata;
      a_fwd = 1'b1;
    end

    b_val = bus.rt_data;
    b_fwd = 1'b0;
    if (bus.rt_addr != 5'd0 && bus.exm_wen && bus.exm_waddr == bus.rt_addr) begin
      b_val = bus.exm_wdata;
      b_fwd = 1'b1;
    end else if (bus.rt_addr != 5'd0 && bus.mwb_wen && bus.mwb_waddr == bus.rt_addr) begin
      b_val = bus.mwb_wdata;
      b_fwd = 1'b1;
    end
  end

  // Operand construction; uses_a/uses_b gate which forwards count as a hit.
  always_comb begin
    op1_n  = '0;
    op2_n  = '0;
    err_n  = 1'b0;
    uses_a = 1'b0;
    uses_b = 1'b0;
    unique case (bus.src_sel)
      3'd0: begin
        op1_n  = a_val;
        op2_n  = b_val;
        uses_a = 1'b1;
        uses_b = 1'b1;
      end
      3'd1: begin
        op1_n  = a_val;
        op2_n  = DATA_W'(bus.imm);
        uses_a = 1'b1;
      end
      3'd2: begin
        op1_n  = a_val;
        op2_n  = DATA_W'($signed(bus.imm));
        uses_a = 1'b1;
      end
      3'd3: begin
        op1_n  = b_val;
        op2_n  = DATA_W'(a_val[SHAMT_W-1:0]);
        uses_a = 1'b1;
        uses_b = 1'b1;
      end
      3'd4: begin
        op1_n  = b_val;
        op2_n  = DATA_W'(bus.shamt);
        uses_b = 1'b1;
      end
      3'd5: begin
        op1_n  = '0;
        op2_n  = DATA_W'(bus.imm) << (DATA_W - IMM_W);
      end
      default: begin
        op1_n  = '1;
        op2_n  = '1;
        err_n  = 1'b1;
      end
    endcase
    hit = (uses_a & a_fwd) | (uses_b & b_fwd);
  end

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  // Pipeline register next-state: flush wins, then accept, then drain.
  always_comb begin
    out_valid_d = out_valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    sel_err_d   = sel_err_q;
    fwd_hits_d  = fwd_hits_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      op1_d       = op1_n;
      op2_d       = op2_n;
      sel_err_d   = err_n;
      if (hit && fwd_hits_q != {CNT_W{1'b1}}) begin
        fwd_hits_d = fwd_hits_q + CNT_W'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      sel_err_q   <= 1'b0;
      fwd_hits_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      sel_err_q   <= sel_err_d;
      fwd_hits_q  <= fwd_hits_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.op1       = op1_q;
  assign bus.op2       = op2_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.fwd_hits  = fwd_hits_q;

endmodule
